// File: rtl/riscv_mem_pkg.sv
// Shared encodings for the memory port arbiter: FSM states, owner ids, latency bound.
package riscv_mem_pkg;

  localparam int LAT_MAX = 15;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_RESP = 2'd2
  } state_e;

  typedef enum logic {
    OWN_IF = 1'b0,
    OWN_LS = 1'b1
  } owner_e;

endpackage

// File: rtl/rr_arbiter2.sv
// Two-way round-robin pick between fetch (bit 0) and load/store (bit 1).
// Combinational; on contention the requester not granted last wins.
module rr_arbiter2
  import riscv_mem_pkg::*;
(
  input  logic [1:0] req,
  input  owner_e     last,
  input  logic       enable,
  output logic [1:0] gnt,
  output owner_e     last_nxt
);

  assign gnt[1] = enable & req[1] & (~req[0] | (last == OWN_IF));
  assign gnt[0] = enable & req[0] & (~req[1] | (last == OWN_LS));

  // Pointer only moves when a grant actually issues.
  assign last_nxt = gnt[1] ? OWN_LS : (gnt[0] ? OWN_IF : last);

endmodule

// File: rtl/mem_port_arbiter.sv
// Shares one fixed-latency memory port between fetch and load/store; grant to rvalid is LAT+1 cycles.
// Requests wait (req held) while a transaction is outstanding; a new grant may overlap the previous rvalid.
module mem_port_arbiter
  import riscv_mem_pkg::*;
#(
  parameter int ADDR_W = 32,
  parameter int DATA_W = 32,
  parameter int LAT    = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ls_req,
  input  logic              ls_we,
  input  logic [ADDR_W-1:0] ls_addr,
  input  logic [DATA_W-1:0] ls_wdata,
  output logic              ls_gnt,
  output logic              ls_rvalid,
  output logic [DATA_W-1:0] ls_rdata,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  localparam logic [3:0] CNT_INIT = 4'(LAT - 1);

  state_e            state_q, state_d;
  owner_e            owner_q, owner_d;
  owner_e            last_q, last_d;
  logic [3:0]        cnt_q, cnt_d;
  logic              we_q, we_d;
  logic              resp_ld;
  logic              arb_en;
  logic [1:0]        arb_gnt;
  logic              if_rvalid_q, ls_rvalid_q;
  logic [DATA_W-1:0] if_rdata_q, ls_rdata_q;

  // Gating with rst keeps grants and memory strobes quiet while reset is held.
  assign arb_en = rst & ((state_q == ST_IDLE) | (state_q == ST_RESP));

  rr_arbiter2 u_arb (
    .req      ({ls_req, if_req}),
    .last     (last_q),
    .enable   (arb_en),
    .gnt      (arb_gnt),
    .last_nxt (last_d)
  );

  assign if_gnt = arb_gnt[0];
  assign ls_gnt = arb_gnt[1];
  assign mem_en = if_gnt | ls_gnt;
  assign mem_we = ls_gnt & ls_we;

  always_comb begin
    mem_addr  = '0;
    mem_wdata = '0;
    if (ls_gnt) begin
      mem_addr = ls_addr;
      if (ls_we) mem_wdata = ls_wdata;
    end else if (if_gnt) begin
      mem_addr = if_addr;
    end
  end

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    owner_d = owner_q;
    we_d    = we_q;
    resp_ld = 1'b0;
    case (state_q)
      ST_IDLE, ST_RESP: begin
        if (mem_en) begin
          state_d = ST_WAIT;
          cnt_d   = CNT_INIT;
          owner_d = ls_gnt ? OWN_LS : OWN_IF;
          we_d    = mem_we;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_WAIT: begin
        if (cnt_q != 4'd0) begin
          cnt_d = cnt_q - 4'd1;
        end else begin
          state_d = ST_RESP;
          resp_ld = 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q     <= ST_IDLE;
      owner_q     <= OWN_IF;
      last_q      <= OWN_IF;
      cnt_q       <= 4'd0;
      we_q        <= 1'b0;
      if_rvalid_q <= 1'b0;
      ls_rvalid_q <= 1'b0;
      if_rdata_q  <= '0;
      ls_rdata_q  <= '0;
    end else begin
      state_q     <= state_d;
      owner_q     <= owner_d;
      last_q      <= last_d;
      cnt_q       <= cnt_d;
      we_q        <= we_d;
      if_rvalid_q <= resp_ld & (owner_q == OWN_IF);
      ls_rvalid_q <= resp_ld & (owner_q == OWN_LS);
      if (resp_ld && owner_q == OWN_IF) if_rdata_q <= mem_rdata;
      if (resp_ld && owner_q == OWN_LS) ls_rdata_q <= we_q ? '0 : mem_rdata;
    end
  end

  assign if_rvalid = if_rvalid_q;
  assign ls_rvalid = ls_rvalid_q;
  assign if_rdata  = if_rdata_q;
  assign ls_rdata  = ls_rdata_q;
  assign busy      = (state_q == ST_WAIT);

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: two instances (LAT=2 and LAT=1) share one clock, each with its own
// memory model, stimulus, grant predictor and response scoreboard.
module tb_mem_port_arbiter;

  localparam int AW = 32;
  localparam int DW = 32;

  typedef struct {
    bit          ls;
    logic [31:0] data;
    int          due;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;
  int done_cnt = 0;

  task automatic chk(input string nm, input int lat, input logic [31:0] act, input logic [31:0] expv);
    n_cmp++;
    if (act !== expv) begin
      n_bad++;
      $display("FAIL %s (LAT=%0d) t=%0t got=%h expected=%h", nm, lat, $time, act, expv);
    end
  endtask

  // Contents of never-written locations: a fixed scramble of the address.
  function automatic logic [31:0] dflt(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h5A5A_0F0F;
  endfunction

  function automatic logic [31:0] rnd_addr();
    return 32'($urandom_range(0, 15)) << 2;
  endfunction

  for (genvar g = 0; g < 2; g++) begin : g_env
    localparam int L = (g == 0) ? 2 : 1;

    logic          rst, if_req, ls_req, ls_we;
    logic [AW-1:0] if_addr, ls_addr, mem_addr;
    logic [DW-1:0] ls_wdata, mem_rdata, mem_wdata, if_rdata, ls_rdata;
    logic          if_gnt, if_rvalid, ls_gnt, ls_rvalid, mem_en, mem_we, busy;

    mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .LAT(L)) dut (
      .clk       (clk),
      .rst       (rst),
      .if_req    (if_req),
      .if_addr   (if_addr),
      .if_gnt    (if_gnt),
      .if_rvalid (if_rvalid),
      .if_rdata  (if_rdata),
      .ls_req    (ls_req),
      .ls_we     (ls_we),
      .ls_addr   (ls_addr),
      .ls_wdata  (ls_wdata),
      .ls_gnt    (ls_gnt),
      .ls_rvalid (ls_rvalid),
      .ls_rdata  (ls_rdata),
      .mem_en    (mem_en),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .busy      (busy)
    );

    int          cyc = 0;
    logic [31:0] mem     [logic [31:0]];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] pipe    [16];
    logic [31:0] cap;
    exp_t        q[$];
    bit          last_ls;
    logic [31:0] exp_ifd, exp_lsd;

    always @(posedge clk) cyc <= cyc + 1;

    // Memory array: read data appears exactly L cycles after the strobe, garbage otherwise.
    always @(negedge clk) begin
      cap = $urandom;
      if (mem_en && mem_we) mem[mem_addr] = mem_wdata;
      else if (mem_en) cap = mem.exists(mem_addr) ? mem[mem_addr] : dflt(mem_addr);
    end

    always @(posedge clk) begin
      #1;
      for (int k = 15; k > 0; k--) pipe[k] = pipe[k-1];
      pipe[0]   = cap;
      mem_rdata = pipe[L-1];
    end

    // Grant predictor: one access in flight; port frees in the response cycle; alternate on contention.
    always @(negedge clk) begin : predict
      bit          freed, win_if, win_ls;
      logic [31:0] a, exp_addr;
      exp_t        e;
      if (!rst) begin
        q.delete();
        last_ls = 1'b0;
        chk("rst_gnt", L, {if_gnt, ls_gnt}, 0);
        chk("rst_mem_en", L, {mem_en, mem_we}, 0);
        chk("rst_mem_addr", L, mem_addr, 0);
        chk("rst_mem_wdata", L, mem_wdata, 0);
        chk("rst_busy", L, busy, 0);
      end else begin
        freed = (q.size() == 0) || (q[$].due == cyc);
        chk("busy", L, busy, (q.size() != 0) && (q[0].due > cyc));
        win_ls = freed && ls_req && (!if_req || !last_ls);
        win_if = freed && if_req && !win_ls;
        exp_addr = win_ls ? ls_addr : (win_if ? if_addr : 32'd0);
        chk("if_gnt", L, if_gnt, win_if);
        chk("ls_gnt", L, ls_gnt, win_ls);
        chk("mem_en", L, mem_en, win_if || win_ls);
        chk("mem_we", L, mem_we, win_ls && ls_we);
        chk("mem_addr", L, mem_addr, exp_addr);
        chk("mem_wdata", L, mem_wdata, (win_ls && ls_we) ? ls_wdata : 32'd0);
        if (win_if || win_ls) begin
          a     = exp_addr;
          e.ls  = win_ls;
          e.due = cyc + L + 1;
          if (win_ls && ls_we) begin
            e.data     = 32'd0;
            ref_mem[a] = ls_wdata;
          end else begin
            e.data = ref_mem.exists(a) ? ref_mem[a] : dflt(a);
          end
          q.push_back(e);
          last_ls = win_ls;
        end
      end
    end

    // Response monitor: pops the scoreboard whenever a response shows up or falls due.
    always @(negedge clk) begin : monitor
      exp_t e;
      if (!rst) begin
        exp_ifd = 32'd0;
        exp_lsd = 32'd0;
        chk("rst_rvalid", L, {if_rvalid, ls_rvalid}, 0);
        chk("rst_if_rdata", L, if_rdata, 0);
        chk("rst_ls_rdata", L, ls_rdata, 0);
      end else begin
        if ((q.size() != 0 && q[0].due <= cyc) || if_rvalid || ls_rvalid) begin
          if (q.size() == 0) begin
            chk("unexpected_rvalid", L, {if_rvalid, ls_rvalid}, 0);
          end else begin
            e = q.pop_front();
            chk("rvalid_cycle", L, cyc, e.due);
            chk("if_rvalid", L, if_rvalid, !e.ls);
            chk("ls_rvalid", L, ls_rvalid, e.ls);
            if (e.ls) exp_lsd = e.data;
            else exp_ifd = e.data;
          end
        end
        chk("if_rdata", L, if_rdata, exp_ifd);
        chk("ls_rdata", L, ls_rdata, exp_lsd);
      end
    end

    task automatic nxt();
      @(posedge clk);
      #1;
    endtask

    // Returns at posedge+1 of the cycle after the grant was seen.
    task automatic wait_gnt(input bit ls);
      int n;
      for (n = 0; n < 40; n++) begin
        @(negedge clk);
        if (ls ? ls_gnt : if_gnt) break;
      end
      if (n == 40) begin
        n_cmp++;
        n_bad++;
        $display("FAIL gnt_timeout (LAT=%0d) t=%0t got=no grant expected=grant to %s", L, $time, ls ? "ls" : "if");
      end
      nxt();
    endtask

    initial begin : stim
      bit g_if, g_ls;
      rst = 1'b0; if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
      if_addr = '0; ls_addr = '0; ls_wdata = '0;
      repeat (3) nxt();
      rst = 1'b1;

      if_req = 1'b1; if_addr = 32'h10;
      wait_gnt(1'b0);
      if_req = 1'b0; if_addr = '0;
      repeat (L + 2) nxt();

      ls_req = 1'b1; ls_we = 1'b1; ls_addr = 32'h20; ls_wdata = 32'hDEAD_BEEF;
      wait_gnt(1'b1);
      ls_we = 1'b0; ls_wdata = '0;
      wait_gnt(1'b1);
      ls_req = 1'b0;
      repeat (L + 2) nxt();

      if_req = 1'b1; ls_req = 1'b1; if_addr = rnd_addr(); ls_addr = rnd_addr();
      for (int c = 0; c < 8 * (L + 1); c++) begin
        @(negedge clk);
        g_if = if_gnt; g_ls = ls_gnt;
        nxt();
        if (g_if) if_addr = rnd_addr();
        if (g_ls) begin
          ls_addr = rnd_addr(); ls_we = 1'($urandom); ls_wdata = $urandom;
        end
      end
      if_req = 1'b0; ls_req = 1'b0; ls_we = 1'b0;
      repeat (L + 2) nxt();

      ls_req = 1'b1; ls_addr = 32'h24;
      wait_gnt(1'b1);
      ls_req = 1'b0;
      #2;
      rst = 1'b0;
      #1;
      chk("async_gnt", L, {if_gnt, ls_gnt}, 0);
      chk("async_mem", L, {mem_en, mem_we}, 0);
      chk("async_mem_addr", L, mem_addr, 0);
      chk("async_busy", L, busy, 0);
      chk("async_rvalid", L, {if_rvalid, ls_rvalid}, 0);
      chk("async_if_rdata", L, if_rdata, 0);
      chk("async_ls_rdata", L, ls_rdata, 0);
      repeat (2) nxt();
      rst = 1'b1;

      if_req = 1'b1; ls_req = 1'b1; if_addr = 32'h30; ls_addr = 32'h34;
      wait_gnt(1'b1);
      ls_req = 1'b0;
      wait_gnt(1'b0);
      if_req = 1'b0;
      repeat (L + 2) nxt();

      for (int c = 0; c < 600; c++) begin
        @(negedge clk);
        g_if = if_gnt; g_ls = ls_gnt;
        nxt();
        if (if_req && g_if) if_req = 1'b0;
        if (ls_req && g_ls) ls_req = 1'b0;
        if (!if_req) begin
          if ($urandom_range(0, 99) < 40) begin
            if_req = 1'b1; if_addr = rnd_addr();
          end
        end else if ($urandom_range(0, 31) == 0) begin
          if_req = 1'b0;
        end
        if (!ls_req) begin
          if ($urandom_range(0, 99) < 40) begin
            ls_req = 1'b1; ls_addr = rnd_addr(); ls_we = 1'($urandom); ls_wdata = $urandom;
          end
        end else if ($urandom_range(0, 31) == 0) begin
          ls_req = 1'b0;
        end
      end
      if_req = 1'b0; ls_req = 1'b0;
      repeat (L + 3) nxt();
      done_cnt++;
    end
  end

  initial begin : finish_ctl
    for (int c = 0; c < 20000 && done_cnt < 2; c++) @(posedge clk);
    if (done_cnt < 2) begin
      n_cmp++;
      n_bad++;
      $display("FAIL run_timeout got=%0d finished expected=2", done_cnt);
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
